// File: rtl/jk_button_request_gen_if.sv
// Button-side bundle for jk_button_request_gen: raw push-button inputs and
// the clean j/k requests, debounced levels and drop indication it produces.
interface jk_button_request_gen_if;
  logic btn_on_raw;
  logic btn_off_raw;
  logic j;
  logic k;
  logic on_level;
  logic off_level;
  logic dropped;

  modport master (
    output btn_on_raw, btn_off_raw,
    input  j, k, on_level, off_level, dropped
  );

  modport slave (
    input  btn_on_raw, btn_off_raw,
    output j, k, on_level, off_level, dropped
  );
endinterface

// File: rtl/jk_button_request_gen.sv
// Front end for the OFF/ON j/k machine: synchronises and debounces two raw
// buttons, turns clean presses into one-cycle j/k requests with off priority and lockout.
module jk_button_request_gen #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int LOCKOUT_CYCLES  = 8
) (
  input  logic                  clk,
  input  logic                  areset_n,
  jk_button_request_gen_if.slave bus
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int LW = $clog2(LOCKOUT_CYCLES + 1) + 1;
  localparam logic [CW-1:0] CNT_MAX   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [LW-1:0] LOCK_LOAD = LW'(LOCKOUT_CYCLES);

  // Bit 0 carries the "on" button, bit 1 the "off" button throughout.
  logic [1:0]    raw_s;
  logic [1:0]    sync1_r;
  logic [1:0]    sync2_r;
  logic [1:0]    level_r;
  logic [1:0]    level_d_r;
  logic [CW-1:0] cnt_r [2];
  logic [LW-1:0] lock_r;
  logic          j_r;
  logic          k_r;
  logic          dropped_r;

  logic [1:0]    press_s;
  logic          j_s;
  logic          k_s;
  logic          dropped_s;
  logic [LW-1:0] lock_s;

  assign raw_s = {bus.btn_off_raw, bus.btn_on_raw};

  // Two-flop synchroniser per button.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      sync1_r <= 2'b00;
      sync2_r <= 2'b00;
    end else begin
      sync1_r <= raw_s;
      sync2_r <= sync1_r;
    end
  end

  // Debounce: level flips only after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      level_r   <= 2'b00;
      level_d_r <= 2'b00;
      for (int b = 0; b < 2; b++) begin
        cnt_r[b] <= '0;
      end
    end else begin
      level_d_r <= level_r;
      for (int b = 0; b < 2; b++) begin
        if (sync2_r[b] == level_r[b]) begin
          cnt_r[b] <= '0;
        end else if (cnt_r[b] == CNT_MAX) begin
          level_r[b] <= sync2_r[b];
          cnt_r[b]   <= '0;
        end else begin
          cnt_r[b] <= cnt_r[b] + 1'b1;
        end
      end
    end
  end

  assign press_s = level_r & ~level_d_r;

  // Arbitration: lockout drops everything, off wins a tie, and the loser is reported.
  always_comb begin
    j_s       = 1'b0;
    k_s       = 1'b0;
    dropped_s = 1'b0;
    lock_s    = lock_r;
    if (press_s == 2'b00) begin
      dropped_s = 1'b0;
    end else if (lock_r != '0) begin
      dropped_s = 1'b1;
    end else if (press_s == 2'b11) begin
      k_s       = 1'b1;
      dropped_s = 1'b1;
    end else if (press_s[1]) begin
      k_s = 1'b1;
    end else begin
      j_s = 1'b1;
    end
    if (j_s || k_s) begin
      lock_s = LOCK_LOAD;
    end else if (lock_r != '0) begin
      lock_s = lock_r - 1'b1;
    end else begin
      lock_s = '0;
    end
  end

  // Registered request outputs and lockout counter.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      j_r       <= 1'b0;
      k_r       <= 1'b0;
      dropped_r <= 1'b0;
      lock_r    <= '0;
    end else begin
      j_r       <= j_s;
      k_r       <= k_s;
      dropped_r <= dropped_s;
      lock_r    <= lock_s;
    end
  end

  assign bus.j         = j_r;
  assign bus.k         = k_r;
  assign bus.dropped   = dropped_r;
  assign bus.on_level  = level_r[0];
  assign bus.off_level = level_r[1];

endmodule
